data_mem_ctrl: RTL and testbench

//  Parametrised memory-stage controller. Drives a multi-cycle data memory through a
//  req/valid handshake and stalls the pipeline until each LW/SW completes. Performs

---
 rtl/data_mem_ctrl.sv | 149 ++++++++++++++
 tb/tb_data_mem_ctrl.sv | 299 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/data_mem_ctrl.sv
// data_mem_ctrl: memory-stage controller. Runs LW/SW through a multi-cycle
// req/valid memory handshake while stalling the pipeline, and performs byte-lane
// immediate insertion without stalling.
// Optional feature macro: MEM_TIMEOUT_EN (WAIT-state timeout with err flag).
module data_mem_ctrl #(
   parameter int unsigned DATA_W = 16,
   parameter int unsigned ADDR_W = 16,
   parameter int unsigned TO_CYC = 64
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          mem_read,
   input  logic                          mem_write,
   input  logic [ADDR_W-1:0]             addr,
   input  logic [DATA_W-1:0]             w_data,
   input  logic                          byte_op,
   input  logic [$clog2(DATA_W/8)-1:0]   lane,
   input  logic [7:0]                    imm8,
   input  logic [DATA_W-1:0]             reg_old,
   output logic                          mem_en,
   output logic                          mem_wr,
   output logic [ADDR_W-1:0]             mem_addr,
   output logic [DATA_W-1:0]             mem_wdata,
   input  logic [DATA_W-1:0]             mem_rdata,
   input  logic                          mem_valid,
   output logic                          stall,
   output logic [DATA_W-1:0]             r_data,
   output logic                          r_valid,
   output logic                          err
);

   localparam int unsigned NL = DATA_W / 8;
   localparam int unsigned LW = $clog2(NL);

   typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DONE} state_t;

   state_t            state_q, state_d;
   logic              req;
   logic              issue;
   logic              timeout;
   logic [DATA_W-1:0] rd_q;

   // Write wins when both request lines are high
   assign req = mem_read | mem_write;

   // Byte-offset bits of the address are dropped by word alignment
   logic unused_addr;
   assign unused_addr = ^addr[LW-1:0];

`ifdef MEM_TIMEOUT_EN
   localparam int unsigned CW = $clog2(TO_CYC + 1);
   logic [CW-1:0] to_cnt;

   // Count WAIT cycles; cleared as the access is issued
   always_ff @(posedge clk) begin
      if (rst || issue)
         to_cnt <= '0;
      else if (state_q == S_WAIT)
         to_cnt <= to_cnt + CW'(1);
   end

   // A response in the last allowed cycle still completes normally
   assign timeout = (state_q == S_WAIT) && !mem_valid && (to_cnt == CW'(TO_CYC - 1));

   // err marks the DONE cycle of a timed-out access
   always_ff @(posedge clk) begin
      if (rst)
         err <= 1'b0;
      else
         err <= timeout;
   end
`else
   logic unused_cfg;
   assign unused_cfg = ^TO_CYC;
   assign timeout    = 1'b0;
   assign err        = 1'b0;
`endif

   // State register
   always_ff @(posedge clk) begin
      if (rst)
         state_q <= S_IDLE;
      else
         state_q <= state_d;
   end

   // Next state, stall and writeback result
   always_comb begin
      state_d = state_q;
      issue   = 1'b0;
      stall   = 1'b0;
      r_valid = 1'b0;
      r_data  = '0;
      case (state_q)
         S_IDLE: begin
            if (req) begin
               issue   = 1'b1;
               stall   = 1'b1;
               state_d = S_WAIT;
            end else if (byte_op) begin
               r_valid = 1'b1;
               r_data  = reg_old;
               for (int i = 0; i < int'(NL); i++) begin
                  if (lane == LW'(i))
                     r_data[i*8 +: 8] = imm8;
               end
            end
         end
         S_WAIT: begin
            stall = 1'b1;
            if (mem_valid || timeout)
               state_d = S_DONE;
         end
         S_DONE: begin
            state_d = S_IDLE;
            r_valid = !mem_wr && !err;
            r_data  = err ? '0 : rd_q;
         end
         default: state_d = S_IDLE;
      endcase
      if (rst) begin
         issue   = 1'b0;
         stall   = 1'b0;
         r_valid = 1'b0;
         r_data  = '0;
      end
   end

   // Memory request registers and captured read data
   always_ff @(posedge clk) begin
      if (rst) begin
         mem_en    <= 1'b0;
         mem_wr    <= 1'b0;
         mem_addr  <= '0;
         mem_wdata <= '0;
         rd_q      <= '0;
      end else begin
         mem_en <= issue;
         if (issue) begin
            mem_wr    <= mem_write;
            mem_addr  <= {addr[ADDR_W-1:LW], LW'(0)};
            mem_wdata <= w_data;
         end
         if ((state_q == S_WAIT) && mem_valid && !mem_wr)
            rd_q <= mem_rdata;
      end
   end

endmodule

// File: tb/tb_data_mem_ctrl.sv
// Self-checking bench for data_mem_ctrl (DATA_W=16) with a latency-programmable
// memory responder and a word-array reference model.
`timescale 1ns/1ps
module tb_data_mem_ctrl;

   localparam int unsigned DATA_W = 16;
   localparam int unsigned ADDR_W = 16;
   localparam int unsigned TO_CYC = 8;

   logic              clk       = 1'b0;
   logic              rst       = 1'b1;
   logic              mem_read  = 1'b0;
   logic              mem_write = 1'b0;
   logic [15:0]       addr      = '0;
   logic [15:0]       w_data    = '0;
   logic              byte_op   = 1'b0;
   logic [0:0]        lane      = '0;
   logic [7:0]        imm8      = '0;
   logic [15:0]       reg_old   = '0;
   logic              mem_en, mem_wr, stall, r_valid, err;
   logic [15:0]       mem_addr, mem_wdata, r_data;
   logic [15:0]       mem_rdata = '0;
   logic              mem_valid = 1'b0;

   int n_checks = 0;
   int n_fail   = 0;

   // memory responder state
   bit [15:0]   env_mem [0:65535];
   bit [15:0]   ref_mem [0:65535];
   int          lat   = 3;
   bit          mute  = 1'b0;
   bit          stray = 1'b0;
   int          cnt   = 0;
   logic [15:0] req_a = '0;

   data_mem_ctrl #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .TO_CYC(TO_CYC)) dut (
      .clk(clk), .rst(rst), .mem_read(mem_read), .mem_write(mem_write),
      .addr(addr), .w_data(w_data), .byte_op(byte_op), .lane(lane),
      .imm8(imm8), .reg_old(reg_old), .mem_en(mem_en), .mem_wr(mem_wr),
      .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
      .mem_valid(mem_valid), .stall(stall), .r_data(r_data),
      .r_valid(r_valid), .err(err)
   );

   always #5 clk = ~clk;

   // Memory: request seen in cycle k responds in cycle k+lat-1
   always @(negedge clk) begin
      if (mem_en) begin
         cnt   = mute ? 0 : lat;
         req_a = mem_addr;
         if (mem_wr) env_mem[mem_addr] = mem_wdata;
      end else if (cnt > 0) begin
         cnt = cnt - 1;
      end
      if (cnt == 1 || stray) begin
         mem_valid = 1'b1;
         mem_rdata = stray ? 16'hDEAD : env_mem[req_a];
      end else begin
         mem_valid = 1'b0;
         mem_rdata = 16'($urandom);
      end
   end

   function automatic logic [15:0] ins_model(input logic [0:0] l, input logic [7:0] b,
                                             input logic [15:0] old);
      int          sh;
      logic [15:0] mask;
      sh   = 8 * int'(l);
      mask = 16'h00FF << sh;
      return (old & ~mask) | (16'(b) << sh);
   endfunction

   task automatic test_reset();
      rst = 1'b1; byte_op = 1'b1; reg_old = 16'h1234; imm8 = 8'h77;
      @(posedge clk); #1;
      @(posedge clk); #3;
      n_checks++;
      if ({stall, r_valid, r_data} !== 18'h0) begin
         n_fail++;
         $display("FAIL reset_comb: stall=%b r_valid=%b r_data=%h, required all 0", stall, r_valid, r_data);
      end
      n_checks++;
      if ({mem_en, mem_wr, err, mem_addr, mem_wdata} !== 35'h0) begin
         n_fail++;
         $display("FAIL reset_regs: en=%b wr=%b err=%b addr=%h wdata=%h, required all 0",
                  mem_en, mem_wr, err, mem_addr, mem_wdata);
      end
      @(posedge clk); #1;
      rst = 1'b0; byte_op = 1'b0;
   endtask

   // One LW/SW access; checks handshake, stall length and writeback
   task automatic do_access(input bit rd, input bit wr, input logic [15:0] a,
                            input logic [15:0] wd, input int l);
      int          scnt, encnt;
      bit          done;
      logic [15:0] al, expd;
      lat  = l;
      al   = {a[15:1], 1'b0};
      expd = ref_mem[al];
      if (wr) ref_mem[al] = wd;
      @(posedge clk); #1;
      mem_read = rd; mem_write = wr; addr = a; w_data = wd;
      byte_op = 1'($urandom); lane = 1'($urandom); imm8 = 8'($urandom); reg_old = 16'($urandom);
      scnt = 0; encnt = 0; done = 1'b0;
      for (int c = 0; c < 100 && !done; c++) begin
         #2;
         if (mem_en) begin
            encnt++;
            n_checks++;
            if (mem_addr !== al || mem_wr !== wr) begin
               n_fail++;
               $display("FAIL req_addr_wr: addr=%h wr=%b, required addr=%h wr=%b", mem_addr, mem_wr, al, wr);
            end
            if (wr) begin
               n_checks++;
               if (mem_wdata !== wd) begin
                  n_fail++;
                  $display("FAIL req_wdata: %h, required %h", mem_wdata, wd);
               end
            end
         end
         if (stall) scnt++;
         else begin
            done = 1'b1;
            n_checks++;
            if (r_valid !== !wr || err !== 1'b0) begin
               n_fail++;
               $display("FAIL done_flags: r_valid=%b err=%b, required r_valid=%b err=0", r_valid, err, !wr);
            end
            if (!wr) begin
               n_checks++;
               if (r_data !== expd) begin
                  n_fail++;
                  $display("FAIL load_data @%h: %h, required %h", al, r_data, expd);
               end
            end
         end
         @(posedge clk); #1;
      end
      mem_read = 1'b0; mem_write = 1'b0; byte_op = 1'b0;
      n_checks++;
      if (!done || scnt != 1 + l || encnt != 1) begin
         n_fail++;
         $display("FAIL access_timing: done=%0d stall_cycles=%0d mem_en_cycles=%0d, required 1/%0d/1",
                  done, scnt, encnt, 1 + l);
      end
   endtask

   task automatic test_byte_op(input logic [0:0] l, input logic [7:0] b,
                               input logic [15:0] old, input logic [15:0] expd);
      @(posedge clk); #1;
      byte_op = 1'b1; lane = l; imm8 = b; reg_old = old;
      #2;
      n_checks++;
      if (r_data !== expd || r_valid !== 1'b1 || stall !== 1'b0) begin
         n_fail++;
         $display("FAIL byte_op lane=%0d: r_data=%h r_valid=%b stall=%b, required %h/1/0",
                  l, r_data, r_valid, stall, expd);
      end
      byte_op = 1'b0;
      #1;
      n_checks++;
      if (r_data !== 16'h0 || r_valid !== 1'b0 || stall !== 1'b0) begin
         n_fail++;
         $display("FAIL idle_out: r_data=%h r_valid=%b stall=%b, required 0/0/0", r_data, r_valid, stall);
      end
   endtask

   task automatic test_stray();
      @(posedge clk); #1;
      stray = 1'b1;
      @(posedge clk); #1;
      stray = 1'b0;
      #2;
      n_checks++;
      if ({stall, r_valid, mem_en} !== 3'b000 || r_data !== 16'h0) begin
         n_fail++;
         $display("FAIL stray_valid: stall=%b r_valid=%b mem_en=%b r_data=%h, required all 0",
                  stall, r_valid, mem_en, r_data);
      end
   endtask

   task automatic test_reset_mid_wait();
      lat = 4;
      @(posedge clk); #1;
      mem_read = 1'b1; addr = 16'h0044;
      @(posedge clk); #1;
      @(posedge clk); #1;
      rst = 1'b1; mem_read = 1'b0;
      #2;
      n_checks++;
      if ({stall, r_valid} !== 2'b00 || r_data !== 16'h0) begin
         n_fail++;
         $display("FAIL rst_wait_comb: stall=%b r_valid=%b r_data=%h, required 0", stall, r_valid, r_data);
      end
      @(posedge clk); #1;
      rst = 1'b0;
      for (int c = 0; c < 5; c++) begin
         #2;
         n_checks++;
         if ({stall, r_valid, mem_en, mem_wr, err, mem_addr, mem_wdata} !== 37'h0) begin
            n_fail++;
            $display("FAIL rst_abandon c%0d: stall=%b r_valid=%b en=%b wr=%b err=%b addr=%h wdata=%h, required all 0",
                     c, stall, r_valid, mem_en, mem_wr, err, mem_addr, mem_wdata);
         end
         @(posedge clk); #1;
      end
   endtask

   task automatic test_timeout();
      int scnt;
      bit done;
      mute = 1'b1;
      @(posedge clk); #1;
      mem_read = 1'b1; addr = 16'h0050;
      scnt = 0; done = 1'b0;
      for (int c = 0; c < 40 && !done; c++) begin
         #2;
         if (stall) scnt++;
         else begin
            done = 1'b1;
`ifdef MEM_TIMEOUT_EN
            n_checks++;
            if (err !== 1'b1 || r_valid !== 1'b0 || r_data !== 16'h0) begin
               n_fail++;
               $display("FAIL timeout_done: err=%b r_valid=%b r_data=%h, required 1/0/0", err, r_valid, r_data);
            end
`endif
         end
         @(posedge clk); #1;
      end
      mem_read = 1'b0;
      mute = 1'b0;
`ifdef MEM_TIMEOUT_EN
      n_checks++;
      if (!done || scnt != int'(TO_CYC) + 1) begin
         n_fail++;
         $display("FAIL timeout_len: done=%0d stall_cycles=%0d, required 1/%0d", done, scnt, TO_CYC + 1);
      end
      #2;
      n_checks++;
      if (err !== 1'b0) begin
         n_fail++;
         $display("FAIL err_pulse: err=%b after DONE, required 0", err);
      end
      do_access(1'b1, 1'b0, 16'h0012, 16'h0, int'(TO_CYC));
`else
      n_checks++;
      if (done || scnt != 40 || err !== 1'b0) begin
         n_fail++;
         $display("FAIL no_timeout: done=%0d stall_cycles=%0d err=%b, required 0/40/0", done, scnt, err);
      end
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
`endif
   endtask

   task automatic test_random();
      int          kind;
      logic [0:0]  l;
      logic [7:0]  b;
      logic [15:0] old;
      for (int i = 0; i < 40; i++) begin
         kind = int'($urandom_range(0, 3));
         if (kind == 3) begin
            l = 1'($urandom); b = 8'($urandom); old = 16'($urandom);
            test_byte_op(l, b, old, ins_model(l, b, old));
         end else begin
            do_access(kind != 1, kind != 0, 16'($urandom_range(0, 63)),
                      16'($urandom), int'($urandom_range(1, 5)));
         end
      end
   endtask

   initial begin
      test_reset();
      env_mem[16'h0012] = 16'hBEEF;
      ref_mem[16'h0012] = 16'hBEEF;
      do_access(1'b1, 1'b0, 16'h0013, 16'h0000, 3);
      do_access(1'b0, 1'b1, 16'h0020, 16'h1234, 3);
      do_access(1'b1, 1'b0, 16'h0020, 16'h0000, 3);
      test_byte_op(1'b0, 8'h5A, 16'hAB12, 16'hAB5A);
      test_byte_op(1'b1, 8'h5A, 16'hAB12, 16'h5A12);
      do_access(1'b1, 1'b1, 16'h0031, 16'h7777, 2);
      do_access(1'b1, 1'b0, 16'h0030, 16'h0000, 1);
      test_stray();
      do_access(1'b1, 1'b0, 16'h0012, 16'h0000, 3);
      test_reset_mid_wait();
      test_timeout();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
